retro_memory_port_arbiter: RTL and testbench
============================================

# retro_memory_port_arbiter

Parametrised N-channel successor to the single memory port.
- Merges `Channels` initiator ports onto one target memory port through a registered command slot.
- Keeps a tag FIFO of outstanding reads, so data from long-latency targets (DRAM, SDRAM controllers) returns to the correct initiator in issue order.
- Sits between CPU/PPU/DMA initiators and a shared RAM controller; SRAM-style always-ready targets run at full throughput.

## Interface
- `Channels`, 2: number of initiator ports (2–8).
- `AddressBusWidth`, 16: address width.
- `DataBusWidth`, 1: data width in bytes.
- `OutstandingDepth`, 4: maximum in-flight reads (power of 2, ≥2).

- `Clk` in 1: single clock, all logic rising-edge.
- `Reset` in 1: asynchronous, active-high.
- `IAddress` in `Channels*AddressBusWidth`: per-channel address, channel c at slice c.
- `IDout` in `Channels*8*DataBusWidth`: per-channel write data.
- `IAccess` in `Channels*DataBusWidth`: per-channel byte enables; any bit set = request.
- `IWrite` in `Channels`: 1 = write, 0 = read.
- `IReady` out `Channels`: accept pulse for the channel's current request.
- `IDataReady` out `Channels`: read data valid for that channel.
- `IDin` out `8*DataBusWidth`: read data, shared by all channels, qualified by `IDataReady`.
- `TAddress` out `AddressBusWidth`: target address.
- `TDout` out `8*DataBusWidth`: target write data.
- `TAccess` out `DataBusWidth`: target byte enables; nonzero = command valid.
- `TWrite` out 1: target write strobe.
- `TReady` in 1: target accepts the presented command this cycle.
- `TDataReady` in 1: target returns read data this cycle, in FIFO order.
- `TDin` in `8*DataBusWidth`: target read data.

## Operation
**Command slot.** One registered command slot drives `TAddress`, `TDout`, `TAccess` and `TWrite`.
- Slot valid ⇔ `TAccess != 0`.
- Slot free ⇔ `!valid || TReady`.

**Request eligibility.** Channel c requests when `|IAccess[c]`.
- Writes are always eligible.
- Reads are eligible only while `reserved < OutstandingDepth`.

**Grant.** When the slot is free, exactly one eligible channel is granted.
- `IReady[c]` is combinational, high in that same cycle only.
- The granted command loads into the slot at the clock edge.
- Initiators hold their request stable until they see `IReady`.
- Dropping a request before grant is legal and issues nothing.

**Arbitration.** Round-robin.
- Search starts at the channel after the last granted one.
- The pointer advances only on a grant.

**Read tracking.** A granted read pushes the channel index into the tag FIFO and increments `reserved`.
- Each `TDataReady` pops the FIFO head and decrements `reserved`.
- Push and pop in the same cycle leave `reserved` unchanged.

**Read return.** On `TDataReady`, the cycle after it:
- `IDin` = registered `TDin`.
- `IDataReady[head]` = 1 for exactly one cycle.

**Spurious return.** `TDataReady` with the FIFO empty is ignored: no `IDataReady`, no counter change.

**Idle slot.** When no grant occurs and `TReady` is high, the slot is cleared (`TAccess` = 0). `TAddress`/`TDout` hold their last values.

**Reset** (async, any time):
- Slot invalid, FIFO and `reserved` cleared, pointer set so channel 0 has first priority.
- In-flight reads are discarded; the target must be reset alongside.

## Timing
- Reset values:
  - `TAccess` = 0, `TWrite` = 0, `TAddress` = 0, `TDout` = 0.
  - `IDataReady` = 0, `IDin` = 0.
  - `IReady` = 0 (forced low while `Reset` is high).
- Request to target: granted in cycle N, presented on the `T*` outputs in cycle N+1.
- Throughput: one command per cycle when `TReady` is held at 1.
- Backpressure: while `TReady` = 0 with the slot valid, all `T*` outputs hold and all `IReady` are 0.
- Read return latency: target `TDataReady` at cycle M gives `IDataReady` at M+1.
- Read stall: with `reserved == OutstandingDepth`, reads are not granted until the cycle after a pop. Writes continue to be granted in the meantime.

## Configuration
`RETRO_MEMPORT_FIXED_PRIORITY_EN`:
- Defined: strict priority, lowest channel index wins; the round-robin pointer is not implemented.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single channel read: c0 reads 0x1234, target `TReady`=1, `TDataReady` 3 cycles after issue with 0xA5 → `T*` shows 0x1234 read at N+1, `IDataReady[0]`=1 with `IDin`=0xA5 one cycle after `TDataReady`.
- Round robin: c0 and c1 request continuously, `TReady`=1 → grants alternate 0,1,0,1; with the macro defined, c0 is granted every cycle and c1 starves.
- Backpressure: `TReady`=0 for 5 cycles with a command issued → `T*` outputs stable, no `IReady` pulses, resumes on `TReady`=1.
- Outstanding limit: `OutstandingDepth`=4, 5 reads from c1, no returns → 4 granted, 5th held until one `TDataReady` arrives, then granted the next cycle; a write from c0 is granted during the stall.
- Ordering: reads c0, c1, c0 issued, returns 0x11, 0x22, 0x33 → `IDataReady` pulses on c0, c1, c0 with matching data.
- Reset mid-operation: 2 reads outstanding, assert `Reset` → all outputs go to reset values immediately; a subsequent `TDataReady` produces no `IDataReady`.

Source files
------------

// File: rtl/retro_memory_port_arbiter.sv
// N-channel memory port arbiter: registered command slot plus read-tag FIFO.
// Define RETRO_MEMPORT_FIXED_PRIORITY_EN for strict lowest-index priority.
module retro_memory_port_arbiter #(
  parameter int Channels         = 2,
  parameter int AddressBusWidth  = 16,
  parameter int DataBusWidth     = 1,
  parameter int OutstandingDepth = 4
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic [Channels*AddressBusWidth-1:0]  IAddress,
  input  logic [Channels*8*DataBusWidth-1:0]   IDout,
  input  logic [Channels*DataBusWidth-1:0]     IAccess,
  input  logic [Channels-1:0]                  IWrite,
  output logic [Channels-1:0]                  IReady,
  output logic [Channels-1:0]                  IDataReady,
  output logic [8*DataBusWidth-1:0]            IDin,
  output logic [AddressBusWidth-1:0]           TAddress,
  output logic [8*DataBusWidth-1:0]            TDout,
  output logic [DataBusWidth-1:0]              TAccess,
  output logic                                 TWrite,
  input  logic                                 TReady,
  input  logic                                 TDataReady,
  input  logic [8*DataBusWidth-1:0]            TDin
);

  localparam int AW = AddressBusWidth;
  localparam int BW = DataBusWidth;
  localparam int DW = 8 * DataBusWidth;
  localparam int CW = $clog2(Channels);
  localparam int PW = $clog2(OutstandingDepth);
  localparam logic [PW:0] FULL = (PW+1)'(OutstandingDepth);

  logic [Channels-1:0] req;
  logic [Channels-1:0] elig;
  logic                slot_free;
  logic                gvalid;
  logic                grant;
  logic [CW-1:0]       gidx;
  logic                push;
  logic                pop;
  logic [PW:0]         reserved;
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       tags [OutstandingDepth];

  always_comb begin
    for (int c = 0; c < Channels; c++) begin
      req[c]  = |IAccess[c*BW +: BW];
      elig[c] = req[c] && (IWrite[c] || (reserved < FULL));
    end
  end

  assign slot_free = ~|TAccess || TReady;

`ifdef RETRO_MEMPORT_FIXED_PRIORITY_EN
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    for (int c = Channels - 1; c >= 0; c--) begin
      if (elig[c]) begin
        gvalid = 1'b1;
        gidx   = CW'(c);
      end
    end
  end
`else
  logic [CW-1:0] last;

  // Search begins one past the most recent grant.
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    for (int i = 1; i <= Channels; i++) begin
      if (!gvalid && elig[(int'(last) + i) % Channels]) begin
        gvalid = 1'b1;
        gidx   = CW'((int'(last) + i) % Channels);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) last <= CW'(Channels - 1);
    else if (grant) last <= gidx;
  end
`endif

  assign grant = gvalid && slot_free;
  assign push  = grant && !IWrite[gidx];
  assign pop   = TDataReady && (reserved != '0);

  always_comb begin
    IReady = '0;
    if (grant && !Reset) IReady[gidx] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      TAddress <= '0;
      TDout    <= '0;
      TAccess  <= '0;
      TWrite   <= 1'b0;
    end else if (grant) begin
      TAddress <= IAddress[gidx*AW +: AW];
      TDout    <= IDout[gidx*DW +: DW];
      TAccess  <= IAccess[gidx*BW +: BW];
      TWrite   <= IWrite[gidx];
    end else if (TReady) begin
      TAccess  <= '0;
      TWrite   <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) tags[wptr] <= gidx;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr     <= '0;
      rptr     <= '0;
      reserved <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        push && !pop: reserved <= reserved + 1'b1;
        pop && !push: reserved <= reserved - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IDataReady <= '0;
      IDin       <= '0;
    end else begin
      IDataReady <= '0;
      if (pop) begin
        IDataReady[tags[rptr]] <= 1'b1;
        IDin                   <= TDin;
      end
    end
  end

endmodule

// File: tb/tb_retro_memory_port_arbiter.sv
// Bench for retro_memory_port_arbiter: directed scenarios, then random traffic
// checked against a transaction-level model of slot, grants and read tags.
module tb_retro_memory_port_arbiter;

  localparam int C  = 3;
  localparam int AW = 16;
  localparam int BW = 1;
  localparam int DW = 8;
  localparam int D  = 4;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [C*AW-1:0] IAddress;
  logic [C*DW-1:0] IDout;
  logic [C*BW-1:0] IAccess;
  logic [C-1:0]    IWrite;
  logic [C-1:0]    IReady;
  logic [C-1:0]    IDataReady;
  logic [DW-1:0]   IDin;
  logic [AW-1:0]   TAddress;
  logic [DW-1:0]   TDout;
  logic [BW-1:0]   TAccess;
  logic            TWrite;
  logic            TReady;
  logic            TDataReady;
  logic [DW-1:0]   TDin;

  retro_memory_port_arbiter #(
    .Channels(C), .AddressBusWidth(AW),
    .DataBusWidth(BW), .OutstandingDepth(D)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .IAddress(IAddress), .IDout(IDout),
    .IAccess(IAccess), .IWrite(IWrite),
    .IReady(IReady), .IDataReady(IDataReady),
    .IDin(IDin), .TAddress(TAddress),
    .TDout(TDout), .TAccess(TAccess),
    .TWrite(TWrite), .TReady(TReady),
    .TDataReady(TDataReady), .TDin(TDin)
  );

  always #5 Clk = ~Clk;

  logic [AW-1:0] r_addr [C];
  logic [DW-1:0] r_data [C];
  logic [BW-1:0] r_acc  [C];
  logic          r_wr   [C];

  always_comb begin
    for (int c = 0; c < C; c++) begin
      IAddress[c*AW +: AW] = r_addr[c];
      IDout[c*DW +: DW]    = r_data[c];
      IAccess[c*BW +: BW]  = r_acc[c];
      IWrite[c]            = r_wr[c];
    end
  end

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;
  logic [BW-1:0] m_acc;
  logic          m_wr;
  logic [C-1:0]  m_rdy;
  logic [DW-1:0] m_din;
  int            m_last;
  int            m_tags [$];
  int            gnt;
  int            nchk  = 0;
  int            npass = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick();
    for (int k = 0; k < C; k++) begin
`ifdef RETRO_MEMPORT_FIXED_PRIORITY_EN
      int c = k;
`else
      int c = (m_last + 1 + k) % C;
`endif
      if (r_acc[c] != '0 && (r_wr[c] || m_tags.size() < D)) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_addr = '0; m_dout = '0; m_acc = '0; m_wr = 1'b0;
    m_rdy = '0; m_din = '0; m_last = C - 1;
    m_tags.delete();
  endtask

  // One clock: called at a falling edge with inputs set, returns at the next.
  task automatic step();
    logic [C-1:0] exp_rdy;
    int g;
    #1;
    g = -1;
    if (m_acc == '0 || TReady) g = pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("IReady", 64'(IReady), 64'(exp_rdy));
    check("TAccess", 64'(TAccess), 64'(m_acc));
    check("TWrite", 64'(TWrite), 64'(m_wr));
    check("TAddress", 64'(TAddress), 64'(m_addr));
    check("TDout", 64'(TDout), 64'(m_dout));
    check("IDataReady", 64'(IDataReady), 64'(m_rdy));
    if (m_rdy != '0) check("IDin", 64'(IDin), 64'(m_din));
    gnt = g;
    @(negedge Clk);
    m_rdy = '0;
    if (TDataReady && m_tags.size() > 0) begin
      m_rdy[m_tags.pop_front()] = 1'b1;
      m_din = TDin;
    end
    if (g >= 0) begin
      m_addr = r_addr[g]; m_dout = r_data[g];
      m_acc  = r_acc[g];  m_wr   = r_wr[g];
      if (!r_wr[g]) m_tags.push_back(g);
      m_last = g;
      r_acc[g] = '0;
    end else if (TReady) begin
      m_acc = '0; m_wr = 1'b0;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    r_acc[0] = '1; r_wr[0] = 1'b1;
    #1;
    check("rst TAccess", 64'(TAccess), 64'd0);
    check("rst TWrite", 64'(TWrite), 64'd0);
    check("rst TAddress", 64'(TAddress), 64'd0);
    check("rst TDout", 64'(TDout), 64'd0);
    check("rst IDataReady", 64'(IDataReady), 64'd0);
    check("rst IDin", 64'(IDin), 64'd0);
    check("rst IReady", 64'(IReady), 64'd0);
    for (int c = 0; c < C; c++) r_acc[c] = '0;
    TDataReady = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic set_req(input int c, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_addr[c] = a; r_data[c] = d; r_wr[c] = wr; r_acc[c] = '1;
  endtask

  initial begin
    for (int c = 0; c < C; c++) begin
      r_addr[c] = '0; r_data[c] = '0; r_acc[c] = '0; r_wr[c] = 1'b0;
    end
    TReady = 1'b1; TDataReady = 1'b0; TDin = '0;
    model_reset();
    do_reset();

    // single read, data three cycles after issue
    set_req(0, 1'b0, 16'h1234, 8'h00);
    step();
    check("sr grant", 64'(gnt), 64'(0));
    check("sr TAddress", 64'(TAddress), 64'h1234);
    check("sr TAccess", 64'(TAccess), 64'h1);
    check("sr TWrite", 64'(TWrite), 64'h0);
    step(); step(); step();
    TDataReady = 1'b1; TDin = 8'hA5;
    step();
    TDataReady = 1'b0;
    check("sr IDataReady", 64'(IDataReady), 64'b001);
    check("sr IDin", 64'(IDin), 64'hA5);
    step();

    // two channels requesting continuously
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (r_acc[0] == '0) set_req(0, 1'b1, 16'h1000 + 16'(i), 8'(i));
      if (r_acc[1] == '0) set_req(1, 1'b1, 16'h2000 + 16'(i), 8'(i));
      step();
`ifdef RETRO_MEMPORT_FIXED_PRIORITY_EN
      check("rr grant", 64'(gnt), 64'(0));
`else
      check("rr grant", 64'(gnt), 64'(i % 2));
`endif
    end
    r_acc[0] = '0; r_acc[1] = '0;
    step();

    // backpressure with a second request waiting
    TReady = 1'b0;
    set_req(2, 1'b1, 16'hBEEF, 8'h5A);
    step();
    check("bp first grant", 64'(gnt), 64'(2));
    set_req(0, 1'b1, 16'h0102, 8'h33);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp no grant", 64'(gnt), -64'sd1);
      check("bp TAddress hold", 64'(TAddress), 64'hBEEF);
      check("bp TDout hold", 64'(TDout), 64'h5A);
    end
    TReady = 1'b1;
    step();
    check("bp resume", 64'(gnt), 64'(0));
    step();

    // outstanding limit: four reads fill the FIFO, writes still flow
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1'b0, 16'h4000 + 16'(i), 8'h00);
      step();
      check("ol read grant", 64'(gnt), 64'(1));
    end
    set_req(1, 1'b0, 16'h4004, 8'h00);
    set_req(0, 1'b1, 16'h5000, 8'hC3);
    step();
    check("ol write in stall", 64'(gnt), 64'(0));
    step();
    check("ol read held", 64'(gnt), -64'sd1);
    TDataReady = 1'b1; TDin = 8'h77;
    step();
    check("ol held at pop", 64'(gnt), -64'sd1);
    TDataReady = 1'b0;
    step();
    check("ol read after pop", 64'(gnt), 64'(1));
    TDataReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      TDin = 8'h80 + 8'(i);
      step();
    end
    TDataReady = 1'b0;
    step();

    // return ordering across channels
    set_req(0, 1'b0, 16'h0AA0, 8'h00); step();
    set_req(1, 1'b0, 16'h0BB0, 8'h00); step();
    set_req(0, 1'b0, 16'h0CC0, 8'h00); step();
    TDataReady = 1'b1; TDin = 8'h11; step();
    check("ord ch", 64'(IDataReady), 64'b001);
    check("ord data", 64'(IDin), 64'h11);
    TDin = 8'h22; step();
    check("ord ch", 64'(IDataReady), 64'b010);
    check("ord data", 64'(IDin), 64'h22);
    TDin = 8'h33; step();
    check("ord ch", 64'(IDataReady), 64'b001);
    check("ord data", 64'(IDin), 64'h33);
    TDataReady = 1'b0;
    step();

    // reset with reads in flight, then a stale return
    set_req(0, 1'b0, 16'h7000, 8'h00); step();
    set_req(2, 1'b0, 16'h7002, 8'h00); step();
    #2;
    do_reset();
    TDataReady = 1'b1; TDin = 8'hEE;
    step();
    TDataReady = 1'b0;
    check("stale return", 64'(IDataReady), 64'd0);
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < C; c++) begin
        if (r_acc[c] == '0) begin
          if ($urandom_range(2) == 0)
            set_req(c, 1'($urandom), 16'($urandom), 8'($urandom));
        end else if ($urandom_range(15) == 0) begin
          r_acc[c] = '0;
        end
      end
      TReady     = ($urandom_range(3) != 0);
      TDataReady = ($urandom_range(2) == 0);
      TDin       = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
